perm_crossbar_pipe: RTL and testbench
=====================================

Name: perm_crossbar_pipe

Overview:
- Parametrised successor to the fixed 16-lane stage crossbar in the FFT/conv datapath.
- Each cycle it accepts one vector of N lanes of W-bit data and applies a run-time selectable index permutation. The permutations are identity, MSB/LSB index-bit swap, full bit-reversal and perfect shuffle.
- Results pass through a 2-stage clock-enabled pipeline.
- It counts FRAME_LEN vectors per run and raises a sticky start_next_stage to hand off to the next stage.

Parameters:
- N, 16, lane count; power of 2, N >= 4; L = log2(N).
- W, 32, lane data width in bits.
- FRAME_LEN, 16, vectors per run; >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- io_clk_en  in  1  global clock enable; when low, no register changes state.
- io_start  in  1  starts a run; ignored unless FSM is IDLE.
- io_mode  in  2  permutation select; latched into mode_q when a start is accepted.
- io_in_valid  in  1  io_in holds a vector to accept.
- io_in  in  N*W  lane k occupies bits [k*W+W-1 : k*W].
- io_out  out  N*W  permuted vector, same lane packing as io_in.
- io_out_valid  out  1  io_out holds a newly produced vector.
- io_busy  out  1  FSM is not IDLE.
- io_start_next_stage  out  1  sticky run-complete flag.

Behaviour:
- Decided: one clock; reset is synchronous and active-high; ports named clk and reset.
- Effective enable en = io_clk_en. Every state, counter and pipeline update below happens only on a clk edge with en=1. With en=0, all registers and outputs hold.
- FSM states:
  - IDLE -> RUN on en & io_start. This edge also: mode_q<=io_mode, cnt<=0, start_next_stage<=0.
  - RUN: accept = en & io_in_valid. Each accept increments cnt. When the accept occurs with cnt==FRAME_LEN-1, go to DRAIN.
  - DRAIN -> IDLE on the edge where the final vector is loaded into stage B.
- io_start while in RUN or DRAIN is ignored.
- io_in_valid is ignored in IDLE and DRAIN. A vector is never accepted on the same edge as start.
- Stage A, on each en edge:
  - a_data<=io_in on accept.
  - a_valid<=accept.
- Stage B, on each en edge:
  - b_data<=perm(a_data, mode_q) when a_valid.
  - b_valid<=a_valid.
- io_out=b_data; io_out_valid=b_valid.
- Latency: a vector accepted at edge t appears at edge t+2 (counting en edges only). Throughput is 1 vector per en cycle.
- Permutation, out lane i (L-bit index) = in lane j:
  - mode 0: j=i.
  - mode 1: j=i with bits 0 and L-1 swapped (legacy stride mapping).
  - mode 2: j=bit-reverse(i).
  - mode 3: j=rotate-right(i,1).
- Permutation is combinational between stages A and B; no arithmetic, widths unchanged.
- io_start_next_stage:
  - Set to 1 on the edge where the FRAME_LEN-th vector enters stage B, the same edge its io_out_valid rises.
  - Stays 1 until reset or the next accepted start.
- io_busy = (state != IDLE).
- Reset (any state, regardless of en):
  - state=IDLE, cnt=0, mode_q=0.
  - a_valid=0, b_valid=0, io_start_next_stage=0.
  - a_data and b_data are not reset; io_out is undefined until the first valid vector.
  - Reset mid-run drops in-flight vectors; io_out_valid is 0 on the following cycle.
- A mode change is only possible between runs. Within a run, io_mode changes are ignored.

Test Plan:
- Identity: N=16, mode=0, start, then one vector with lane k=k+100 -> 2 cycles after accept, io_out_valid=1 and lane k=k+100; io_out_valid returns to 0 on the next cycle.
- Modes 1-3, lane k=k:
  - mode1 -> out[1]=8, out[3]=10, out[8]=1, out[6]=6.
  - mode2 -> out[1]=8, out[3]=12, out[6]=6.
  - mode3 -> out[1]=8, out[2]=1, out[3]=9.
- Frame handoff: FRAME_LEN=4, four back-to-back valid vectors.
  - io_busy high from the cycle after start.
  - start_next_stage rises together with the 4th io_out_valid.
  - FSM is IDLE on the same edge; start_next_stage stays high; a 5th io_in_valid is not accepted.
- Clock-enable stall: io_clk_en=0 for 3 cycles with a vector in stage A -> io_out, io_out_valid, cnt and state frozen. The vector emerges exactly 1 en-cycle after io_clk_en returns to 1.
- Ignored inputs:
  - io_start during RUN with a different io_mode -> mode_q unchanged; outputs keep the original permutation.
  - io_in_valid in IDLE -> no io_out_valid.
- Reset mid-run: reset after 2 accepts with 1 vector in flight -> next cycle io_out_valid=0, io_busy=0, io_start_next_stage=0. A fresh start then requires the full FRAME_LEN vectors.

Source files
------------

// File: rtl/perm_crossbar_pipe.sv
// Two-stage lane permutation crossbar with frame counting and a sticky hand-off flag.
// Stage A registers the accepted vector; stage B registers its permuted image.

module perm_lane #(
    parameter int N   = 16,
    parameter int W   = 32,
    parameter int L   = 4,
    parameter int IDX = 0
) (
    input  logic [1:0]          mode,
    input  logic [N-1:0][W-1:0] vec,
    output logic [W-1:0]        lane
);
    localparam logic [L-1:0] I = L'(IDX);

    logic [L-1:0] rev, swp, rot, src;

    // Source lane index for this output lane; all terms fold to constants except the mode mux.
    always_comb begin
        rev = '0;
        for (int b = 0; b < L; b++) rev[b] = I[L-1-b];
        swp      = I;
        swp[0]   = I[L-1];
        swp[L-1] = I[0];
        rot      = {I[0], I[L-1:1]};
        case (mode)
            2'd1:    src = swp;
            2'd2:    src = rev;
            2'd3:    src = rot;
            default: src = I;
        endcase
        lane = vec[src];
    end
endmodule

module perm_crossbar_pipe #(
    parameter int N         = 16,
    parameter int W         = 32,
    parameter int FRAME_LEN = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           io_clk_en,
    input  logic           io_start,
    input  logic [1:0]     io_mode,
    input  logic           io_in_valid,
    input  logic [N*W-1:0] io_in,
    output logic [N*W-1:0] io_out,
    output logic           io_out_valid,
    output logic           io_busy,
    output logic           io_start_next_stage
);
    localparam int L  = $clog2(N);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt;
    logic [1:0]          mode_q;
    logic                next_stage_q;
    logic                accept, launch, done;
    logic [2:1]          vld_pipe;
    logic [N-1:0][W-1:0] a_data, b_data, perm_vec;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        launch  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (io_start) begin
                state_d = RUN;
                launch  = 1'b1;
            end
            RUN: if (io_in_valid) begin
                accept = 1'b1;
                if (cnt == LAST) state_d = DRAIN;
            end
            // The final vector sits in stage A here; leave as it moves into B.
            DRAIN: if (vld_pipe[1]) begin
                state_d = IDLE;
                done    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt          <= '0;
            mode_q       <= 2'd0;
            vld_pipe     <= '0;
            next_stage_q <= 1'b0;
        end else if (io_clk_en) begin
            state_q  <= state_d;
            vld_pipe <= {vld_pipe[1], accept};
            if (launch) begin
                mode_q       <= io_mode;
                cnt          <= '0;
                next_stage_q <= 1'b0;
            end
            if (accept) cnt <= cnt + 1'b1;
            if (done) next_stage_q <= 1'b1;
        end
    end

    // Data registers carry no reset; validity is tracked by vld_pipe alone.
    always_ff @(posedge clk) begin
        if (io_clk_en) begin
            if (accept) a_data <= io_in;
            if (vld_pipe[1]) b_data <= perm_vec;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        perm_lane #(.N(N), .W(W), .L(L), .IDX(g)) u_lane (
            .mode (mode_q),
            .vec  (a_data),
            .lane (perm_vec[g])
        );
    end

    assign io_out              = b_data;
    assign io_out_valid        = vld_pipe[2];
    assign io_busy             = (state_q != IDLE);
    assign io_start_next_stage = next_stage_q;
endmodule

// File: tb/tb_perm_crossbar_pipe.sv
// Directed bench for perm_crossbar_pipe: a frame-level reference model checked every cycle,
// plus hand-computed lane values for each permutation mode.

module tb_perm_crossbar_pipe;
    localparam int N  = 16;
    localparam int W  = 32;
    localparam int FL = 4;
    localparam int L  = 4;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          io_clk_en = 1'b1;
    logic          io_start = 1'b0;
    logic [1:0]    io_mode = 2'd0;
    logic          io_in_valid = 1'b0;
    logic [VW-1:0] io_in = '0;
    logic [VW-1:0] io_out;
    logic          io_out_valid, io_busy, io_start_next_stage;

    int checks = 0;
    int errors = 0;

    perm_crossbar_pipe #(.N(N), .W(W), .FRAME_LEN(FL)) dut (
        .clk                 (clk),
        .reset               (reset),
        .io_clk_en           (io_clk_en),
        .io_start            (io_start),
        .io_mode             (io_mode),
        .io_in_valid         (io_in_valid),
        .io_in               (io_in),
        .io_out              (io_out),
        .io_out_valid        (io_out_valid),
        .io_busy             (io_busy),
        .io_start_next_stage (io_start_next_stage)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int src_of(input int i, input logic [1:0] m);
        int j, b0, bh;
        case (m)
            2'd1: begin
                b0 = i & 1;
                bh = (i >> (L - 1)) & 1;
                j  = (i & ~(1 | (1 << (L - 1)))) | bh | (b0 << (L - 1));
            end
            2'd2: begin
                j = 0;
                for (int b = 0; b < L; b++) j = (j << 1) | ((i >> b) & 1);
            end
            2'd3:    j = (i >> 1) | ((i & 1) << (L - 1));
            default: j = i;
        endcase
        return j;
    endfunction

    function automatic logic [VW-1:0] perm(input logic [VW-1:0] v, input logic [1:0] m);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = v[src_of(i, m)*W +: W];
        return r;
    endfunction

    function automatic logic [VW-1:0] mkvec(input int base, input int stp);
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + stp * k);
        return v;
    endfunction

    function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    // Frame-level reference: a run accepts FL vectors, each appears two enabled edges later.
    bit            m_init = 0, m_busy, m_snext, was_busy, a_v, a_last, b_v;
    int            m_left;
    logic [1:0]    m_mode;
    logic [VW-1:0] a_d, b_d;

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1; m_busy = 0; m_snext = 0; m_left = 0; m_mode = 2'd0;
            a_v = 0; a_last = 0; b_v = 0;
        end else if (io_clk_en) begin
            was_busy = m_busy;
            b_v = a_v;
            if (a_v) b_d = perm(a_d, m_mode);
            if (a_v && a_last) begin
                m_snext = 1;
                m_busy  = 0;
            end
            if (!was_busy && io_start) begin
                m_busy = 1; m_left = FL; m_mode = io_mode; m_snext = 0;
            end
            if (was_busy && m_left > 0 && io_in_valid) begin
                a_v = 1; a_d = io_in; a_last = (m_left == 1); m_left--;
            end else begin
                a_v = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_out_valid", VW'(io_out_valid), VW'(b_v));
            chk("model_busy", VW'(io_busy), VW'(m_busy));
            chk("model_start_next", VW'(io_start_next_stage), VW'(m_snext));
            if (b_v) chk("model_out_data", io_out, b_d);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic [1:0] m);
        io_start = 1'b1;
        io_mode  = m;
        step();
        io_start = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("rst_out_valid", VW'(io_out_valid), '0);
        chk("rst_busy", VW'(io_busy), '0);
        chk("rst_start_next", VW'(io_start_next_stage), '0);
        reset = 1'b0;

        // identity, single vector then gap
        start(2'd0);
        chk("id_busy", VW'(io_busy), VW'(1));
        io_in = mkvec(100, 1); io_in_valid = 1'b1; step(); io_in_valid = 1'b0;
        step();
        chk("id_valid", VW'(io_out_valid), VW'(1));
        chk("id_lane0", VW'(lane(io_out, 0)), VW'(100));
        chk("id_lane15", VW'(lane(io_out, 15)), VW'(115));
        step();
        chk("id_valid_drop", VW'(io_out_valid), '0);
        for (int i = 0; i < 3; i++) begin
            io_in = mkvec(i * 1000, 7); io_in_valid = 1'b1; step(); io_in_valid = 1'b0;
            step(); step();
        end
        chk("id_done", VW'(io_start_next_stage), VW'(1));

        // mode 1; a start with another mode mid-run must be ignored
        start(2'd1);
        io_in = mkvec(0, 1); io_in_valid = 1'b1; step(); io_in_valid = 1'b0;
        io_start = 1'b1; io_mode = 2'd2; step(); io_start = 1'b0;
        chk("m1_lane1", VW'(lane(io_out, 1)), VW'(8));
        chk("m1_lane3", VW'(lane(io_out, 3)), VW'(10));
        chk("m1_lane8", VW'(lane(io_out, 8)), VW'(1));
        chk("m1_lane6", VW'(lane(io_out, 6)), VW'(6));
        io_in_valid = 1'b1; step(); step();
        chk("ign_mode_lane3", VW'(lane(io_out, 3)), VW'(10));
        step(); io_in_valid = 1'b0; step(); step();

        // valid in IDLE is dropped
        io_in = mkvec(5, 5); io_in_valid = 1'b1;
        step(); chk("idle_valid0", VW'(io_out_valid), '0);
        step(); chk("idle_valid1", VW'(io_out_valid), '0);
        io_in_valid = 1'b0;

        // mode 2 with a 3-cycle enable stall holding a vector in stage A
        start(2'd2);
        io_in = mkvec(0, 1); io_in_valid = 1'b1; step();
        io_clk_en = 1'b0; io_in = mkvec(77, 1);
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall_valid", VW'(io_out_valid), '0);
            chk("stall_busy", VW'(io_busy), VW'(1));
        end
        io_in_valid = 1'b0; io_clk_en = 1'b1; step();
        chk("stall_emerge", VW'(io_out_valid), VW'(1));
        chk("m2_lane1", VW'(lane(io_out, 1)), VW'(8));
        chk("m2_lane3", VW'(lane(io_out, 3)), VW'(12));
        chk("m2_lane6", VW'(lane(io_out, 6)), VW'(6));
        io_in = mkvec(50, 3); io_in_valid = 1'b1; step(); step(); step();
        io_in_valid = 1'b0; step(); step();

        // mode 3 frame hand-off with a 5th valid held high
        start(2'd3);
        chk("m3_busy", VW'(io_busy), VW'(1));
        io_in = mkvec(0, 1); io_in_valid = 1'b1; step();
        io_in = mkvec(16, 1); step();
        chk("m3_lane1", VW'(lane(io_out, 1)), VW'(8));
        chk("m3_lane2", VW'(lane(io_out, 2)), VW'(1));
        chk("m3_lane3", VW'(lane(io_out, 3)), VW'(9));
        io_in = mkvec(32, 1); step();
        io_in = mkvec(48, 1); step();
        chk("ho_pre_next", VW'(io_start_next_stage), '0);
        chk("ho_pre_busy", VW'(io_busy), VW'(1));
        io_in = mkvec(64, 1); step();
        chk("ho_valid4", VW'(io_out_valid), VW'(1));
        chk("ho_next", VW'(io_start_next_stage), VW'(1));
        chk("ho_idle", VW'(io_busy), '0);
        chk("ho_lane1", VW'(lane(io_out, 1)), VW'(56));
        step();
        chk("ho_no5th", VW'(io_out_valid), '0);
        chk("ho_sticky", VW'(io_start_next_stage), VW'(1));
        io_in_valid = 1'b0;

        // reset mid-run, then a fresh run needs all FL vectors
        start(2'd0);
        io_in = mkvec(200, 1); io_in_valid = 1'b1; step();
        io_in = mkvec(300, 1); step();
        io_in_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
        chk("mr_valid", VW'(io_out_valid), '0);
        chk("mr_busy", VW'(io_busy), '0);
        chk("mr_next", VW'(io_start_next_stage), '0);
        start(2'd0);
        io_in = mkvec(400, 2); io_in_valid = 1'b1; step(); step(); step();
        io_in_valid = 1'b0; step(); step();
        chk("mr_partial_next", VW'(io_start_next_stage), '0);
        chk("mr_partial_busy", VW'(io_busy), VW'(1));
        io_in_valid = 1'b1; step(); io_in_valid = 1'b0; step();
        chk("mr_full_next", VW'(io_start_next_stage), VW'(1));
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
